// File: rtl/mfsk_modulator_if.sv
// Symbol handshake bundle for the M-ary FSK modulator.
// Source drives valid/data, modulator returns ready.
interface mfsk_modulator_if #(
  parameter int BITS_PER_SYM = 2
);
  logic                    sym_valid;
  logic [BITS_PER_SYM-1:0] sym_data;
  logic                    sym_ready;

  modport master (
    output sym_valid,
    output sym_data,
    input  sym_ready
  );

  modport slave (
    input  sym_valid,
    input  sym_data,
    output sym_ready
  );
endinterface

// File: rtl/mfsk_modulator.sv
// M-ary FSK modulator: one shared DDS (phase accumulator +
// quarter-wave sine LUT), one-deep symbol buffer, offset-binary out.
module mfsk_modulator #(
  parameter int BITS_PER_SYM = 2,
  parameter int PHASE_W      = 24,
  parameter int BASE_FTW     = 336,
  parameter int STEP_FTW     = 336,
  parameter int SYM_CYCLES   = 50000
) (
  input  logic               CLOCK_50,
  input  logic               RESET_n,
  input  logic               CONT_PHASE,
  mfsk_modulator_if.slave    sym,
  output logic [15:0]        signal,
  output logic               sample_valid,
  output logic               sym_start,
  output logic               underrun
);

  localparam int CW = $clog2(SYM_CYCLES);

  localparam logic [14:0] SINE [64] = '{
    15'd0,     15'd804,   15'd1608,  15'd2410,
    15'd3212,  15'd4011,  15'd4808,  15'd5602,
    15'd6393,  15'd7179,  15'd7962,  15'd8739,
    15'd9512,  15'd10278, 15'd11039, 15'd11793,
    15'd12539, 15'd13279, 15'd14010, 15'd14732,
    15'd15446, 15'd16151, 15'd16846, 15'd17530,
    15'd18204, 15'd18867, 15'd19519, 15'd20159,
    15'd20787, 15'd21403, 15'd22006, 15'd22594,
    15'd23170, 15'd23731, 15'd24279, 15'd24811,
    15'd25329, 15'd25832, 15'd26319, 15'd26790,
    15'd27245, 15'd27683, 15'd28105, 15'd28510,
    15'd28898, 15'd29268, 15'd29621, 15'd29956,
    15'd30273, 15'd30571, 15'd30852, 15'd31113,
    15'd31356, 15'd31580, 15'd31785, 15'd31971,
    15'd32137, 15'd32285, 15'd32412, 15'd32521,
    15'd32609, 15'd32678, 15'd32728, 15'd32757
  };

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic [PHASE_W-1:0]      phase_acc;
  logic [PHASE_W-1:0]      cur_ftw;
  logic [CW-1:0]           count;
  logic                    pend_full;
  logic [BITS_PER_SYM-1:0] pend_data;
  logic                    accept;
  logic                    load;
  logic                    add_en;
  logic                    under_nx;
  logic                    cnt_zero;
  logic [7:0]              addr_r;
  logic                    act_d1;

  function automatic logic [PHASE_W-1:0] ftw_of(
    input logic [BITS_PER_SYM-1:0] k
  );
    logic [PHASE_W-1:0] b;
    logic [PHASE_W-1:0] s;
    logic [PHASE_W-1:0] kk;
    b  = PHASE_W'(BASE_FTW);
    s  = PHASE_W'(STEP_FTW);
    kk = PHASE_W'(k);
    return b + s * kk;
  endfunction

  // Q1/Q3 walk the table backwards, Q2/Q3 go below midscale.
  function automatic logic [15:0] lut(input logic [7:0] a);
    logic [5:0]  idx;
    logic [14:0] m;
    idx = a[6] ? ~a[5:0] : a[5:0];
    m   = SINE[idx];
    return a[7] ? (16'h8000 - {1'b0, m})
                : (16'h8000 + {1'b0, m});
  endfunction

  assign cnt_zero      = (count == '0);
  assign accept        = sym.sym_valid && !pend_full;
  assign sym.sym_ready = !pend_full;

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (pend_full) state_nx = ACTIVE;
      end
      (state == ACTIVE): begin
        if (cnt_zero && !pend_full) state_nx = IDLE;
      end
    endcase
  end

  always_comb begin
    add_en   = 1'b0;
    load     = 1'b0;
    under_nx = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        load = pend_full;
      end
      (state == ACTIVE): begin
        add_en   = 1'b1;
        load     = pend_full && cnt_zero;
        under_nx = !pend_full && cnt_zero;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      phase_acc <= '0;
      cur_ftw   <= '0;
      count     <= '0;
      pend_full <= 1'b0;
      pend_data <= '0;
      sym_start <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      sym_start <= load;
      underrun  <= under_nx;
      if (load) begin
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
        pend_data <= sym.sym_data;
      end
      if (load) begin
        cur_ftw <= ftw_of(pend_data);
        count   <= CW'(SYM_CYCLES - 1);
      end else if (add_en && !cnt_zero) begin
        count <= count - CW'(1);
      end
      // A phase clear on load wins over the final add.
      if (load && !CONT_PHASE) begin
        phase_acc <= '0;
      end else if (add_en) begin
        phase_acc <= phase_acc + cur_ftw;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      addr_r       <= '0;
      act_d1       <= 1'b0;
      sample_valid <= 1'b0;
      signal       <= 16'h8000;
    end else begin
      addr_r       <= phase_acc[PHASE_W-1 -: 8];
      act_d1       <= (state == ACTIVE);
      sample_valid <= act_d1;
      signal       <= act_d1 ? lut(addr_r) : 16'h8000;
    end
  end

endmodule

// File: tb/tb_mfsk_modulator.sv
// Directed bench for mfsk_modulator with SYM_CYCLES=8,
// BASE_FTW=STEP_FTW=2**20 so tone k adds (k+1)*2**20 per cycle.
module tb_mfsk_modulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cont = 1'b1;
  logic [15:0] signal;
  logic        sample_valid;
  logic        sym_start;
  logic        underrun;

  int tests = 0;
  int fails = 0;
  int sv_cnt;
  int ur_cnt;
  int ss_cnt;

  mfsk_modulator_if #(.BITS_PER_SYM(2)) sym_if ();

  mfsk_modulator #(
    .BITS_PER_SYM(2),
    .PHASE_W     (24),
    .BASE_FTW    (1 << 20),
    .STEP_FTW    (1 << 20),
    .SYM_CYCLES  (8)
  ) dut (
    .CLOCK_50    (clk),
    .RESET_n     (rst_n),
    .CONT_PHASE  (cont),
    .sym         (sym_if),
    .signal      (signal),
    .sample_valid(sample_valid),
    .sym_start   (sym_start),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [1:0] d);
    sym_if.sym_valid = 1'b1;
    sym_if.sym_data  = d;
    tick();
    sym_if.sym_valid = 1'b0;
  endtask

  task automatic clr();
    sv_cnt = 0;
    ur_cnt = 0;
    ss_cnt = 0;
  endtask

  task automatic acc();
    sv_cnt += int'(sample_valid);
    ur_cnt += int'(underrun);
    ss_cnt += int'(sym_start);
  endtask

  initial begin
    sym_if.sym_valid = 1'b0;
    sym_if.sym_data  = '0;
    repeat (3) tick();

    check("rst_ready", 32'(sym_if.sym_ready), 1);
    check("rst_signal", 32'(signal), 32'h8000);
    check("rst_sv", 32'(sample_valid), 0);
    check("rst_start", 32'(sym_start), 0);
    check("rst_under", 32'(underrun), 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_ready", 32'(sym_if.sym_ready), 1);
    check("idle_sv", 32'(sample_valid), 0);

    // single symbol 0
    offer(2'd0);
    check("t2_ready0", 32'(sym_if.sym_ready), 0);
    check("t2_nostart", 32'(sym_start), 0);
    tick();
    check("t2_start", 32'(sym_start), 1);
    check("t2_sv0", 32'(sample_valid), 0);
    clr();
    for (int i = 2; i <= 12; i++) begin
      tick();
      acc();
      if (i == 3) begin
        check("t2_sv_first", 32'(sample_valid), 1);
        check("t2_s0", 32'(signal), 32'h8000);
      end
      if (i == 4) check("t2_s1", 32'(signal), 32'hB0FB);
      if (i == 5) check("t2_s2", 32'(signal), 32'hDA82);
      if (i == 9) begin
        check("t2_under", 32'(underrun), 1);
        check("t2_phase", 32'(dut.phase_acc), 32'h800000);
      end
      if (i == 10) check("t2_s7", 32'(signal), 32'hAE11);
      if (i == 11) begin
        check("t2_sv_end", 32'(sample_valid), 0);
        check("t2_mid", 32'(signal), 32'h8000);
      end
    end
    check("t2_sv_cnt", sv_cnt, 8);
    check("t2_ur_cnt", ur_cnt, 1);
    check("t2_ss_cnt", ss_cnt, 0);

    // back-to-back 3,1 with continuous phase
    offer(2'd3);
    tick();
    check("t3_start", 32'(sym_start), 1);
    check("t3_ph0", 32'(dut.phase_acc), 32'h800000);
    offer(2'd1);
    check("t3_ready0", 32'(sym_if.sym_ready), 0);
    check("t3_ph1", 32'(dut.phase_acc), 32'hC00000);
    clr();
    for (int i = 3; i <= 20; i++) begin
      tick();
      acc();
      if (i == 9) begin
        check("t3_start2", 32'(sym_start), 1);
        check("t3_ph_load", 32'(dut.phase_acc), 32'h800000);
        check("t3_ftw", 32'(dut.cur_ftw), 32'h200000);
      end
      if (i == 10) check("t3_ph_inc", 32'(dut.phase_acc), 32'hA00000);
      if (i == 17) begin
        check("t3_under", 32'(underrun), 1);
        check("t3_ph_end", 32'(dut.phase_acc), 32'h800000);
      end
    end
    check("t3_sv_cnt", sv_cnt, 16);
    check("t3_ur_cnt", ur_cnt, 1);
    check("t3_ss_cnt", ss_cnt, 1);

    // same with phase cleared per symbol
    cont = 1'b0;
    offer(2'd3);
    tick();
    check("t4_ph_clr", 32'(dut.phase_acc), 32'h0);
    check("t4_start", 32'(sym_start), 1);
    offer(2'd1);
    clr();
    for (int i = 3; i <= 20; i++) begin
      tick();
      acc();
      if (i == 3) check("t4_s0", 32'(signal), 32'h8000);
      if (i == 4) check("t4_s1", 32'(signal), 32'hFFF5);
      if (i == 9) check("t4_ph_clr2", 32'(dut.phase_acc), 32'h0);
      if (i == 11) check("t4_s0b", 32'(signal), 32'h8000);
      if (i == 12) check("t4_s1b", 32'(signal), 32'hDA82);
    end
    check("t4_sv_cnt", sv_cnt, 16);
    check("t4_ur_cnt", ur_cnt, 1);
    cont = 1'b1;

    // backpressure: third symbol held while buffer full
    offer(2'd0);
    tick();
    offer(2'd2);
    sym_if.sym_valid = 1'b1;
    sym_if.sym_data  = 2'd1;
    clr();
    for (int i = 3; i <= 27; i++) begin
      tick();
      acc();
      if (i == 3) check("t5_ready_a", 32'(sym_if.sym_ready), 0);
      if (i == 8) check("t5_ready_b", 32'(sym_if.sym_ready), 0);
      if (i == 9) begin
        check("t5_start2", 32'(sym_start), 1);
        check("t5_ready_c", 32'(sym_if.sym_ready), 1);
        check("t5_ftw2", 32'(dut.cur_ftw), 32'h300000);
      end
      if (i == 10) begin
        check("t5_ready_d", 32'(sym_if.sym_ready), 0);
        sym_if.sym_valid = 1'b0;
      end
      if (i == 17) begin
        check("t5_start3", 32'(sym_start), 1);
        check("t5_ftw3", 32'(dut.cur_ftw), 32'h200000);
      end
      if (i == 25) check("t5_under", 32'(underrun), 1);
    end
    check("t5_sv_cnt", sv_cnt, 24);
    check("t5_ur_cnt", ur_cnt, 1);
    check("t5_ss_cnt", ss_cnt, 2);

    // reset at count=3 of symbol 2, with a symbol pending
    offer(2'd0);
    tick();
    offer(2'd2);
    for (int i = 3; i <= 13; i++) begin
      tick();
      if (i == 9) begin
        sym_if.sym_valid = 1'b1;
        sym_if.sym_data  = 2'd3;
      end
      if (i == 10) sym_if.sym_valid = 1'b0;
    end
    check("t6_count", 32'(dut.count), 3);
    check("t6_pend", 32'(dut.pend_full), 1);
    rst_n = 1'b0;
    #1;
    check("t6_ready", 32'(sym_if.sym_ready), 1);
    check("t6_signal", 32'(signal), 32'h8000);
    check("t6_sv", 32'(sample_valid), 0);
    check("t6_pend_clr", 32'(dut.pend_full), 0);
    check("t6_phase", 32'(dut.phase_acc), 0);
    check("t6_under", 32'(underrun), 0);
    tick();
    tick();
    rst_n = 1'b1;
    clr();
    for (int i = 0; i < 30; i++) begin
      tick();
      acc();
    end
    check("t6_post_ur", ur_cnt, 0);
    check("t6_post_ss", ss_cnt, 0);
    check("t6_post_sv", sv_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
